des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
- Iterative DES Feistel round controller; sits directly downstream of the f-function output permutation (P) and consumes its 32-bit result.
- Holds the L/R halves after the initial permutation and runs 16 rounds, one per clock, using a single shared f-function datapath outside this block.
- Each round presents R and a subkey index to the f-function and the key schedule, then folds the permuted f result back with `L_next = R` and `R_next = L ^ FOut`.
- Produces the pre-output block R16‖L16 for the final permutation stage.

Parameters:
- ROUNDS, 16, number of Feistel rounds; legal range 1..16; the bench checks the default only.

Ports:
- Clk  input  1  rising-edge clock.
- RstN  input  1  asynchronous active-low reset.
- Start  input  1  request to load DataIn and begin; sampled only in IDLE or DONE.
- Decrypt  input  1  subkey order select; sampled with Start and held internally.
- DataIn  input  64  post-IP block; bit i = DES bit i+1; L0 = DataIn[31:0], R0 = DataIn[63:32].
- FOut  input  32  permuted f-function result for the current RightOut/SubkeyIdx; combinational, same cycle.
- RightOut  output  32  current R half, drives the f-function expansion input.
- SubkeyIdx  output  4  subkey number for the key schedule.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse when DataOut becomes valid.
- DataOut  output  64  pre-output; DataOut[31:0] = R16, DataOut[63:32] = L16; held until the next accepted Start.

Behaviour:
- Reset (RstN low, asynchronous, any state, including mid-run):
  - state = IDLE; L, R, round counter, DataOut, Done, Busy = 0; stored Decrypt = 0.
  - Deassertion is synchronised externally; an operation interrupted by reset is abandoned with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start = 1 at an edge → L = DataIn[31:0], R = DataIn[63:32], rnd = 0, latch Decrypt, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge: L ← R, R ← L ^ FOut, rnd ← rnd + 1.
  - When rnd = ROUNDS-1 at the edge: perform the update, set DataOut ← {L_new, R_new} (DataOut[63:32] = L16, DataOut[31:0] = R16), go to DONE.
  - Start is ignored in RUN; no queueing.
- DONE:
  - Done = 1 for exactly this one cycle.
  - Start = 1 → identical load to IDLE, go to RUN (back-to-back, no bubble); else go to IDLE.
- Latency: Start accepted at edge 0; round updates at edges 1..16; Done high in the cycle after edge 16.
  - Throughput: one block per 17 cycles with Start held high.
- Busy = (state == RUN); RightOut = R register; both are valid in every state.
- SubkeyIdx:
  - Decrypt = 0 → rnd (0..15).
  - Decrypt = 1 → 15 - rnd.
  - Outside RUN, SubkeyIdx is driven as in RUN with rnd = 0.
- The round counter is 4 bits and never wraps inside RUN; the transition to DONE takes priority.
- DataIn and Decrypt changing during RUN have no effect.
- DataOut is updated only at the final-round edge; it keeps the previous result through the next run until that run's final edge.

Test Plan:
- Reset and idle: reset mid-RUN (round 7) → Busy = 0, Done = 0, DataOut = 0 immediately; state returns to IDLE; a subsequent Start runs the full 16 rounds.
- Zero f: FOut tied to 0, DataIn = 64'h0123456789ABCDEF, Start → Done after exactly 17 cycles; DataOut = 64'h89ABCDEF01234567 (halves swapped).
- Constant f: FOut = 32'hFFFFFFFF, DataIn = 64'hFEDCBA9876543210 → period-4 Feistel returns the input halves; DataOut = 64'h76543210FEDCBA98.
- Key order: Decrypt = 0 → SubkeyIdx sequence 0,1,...,15 on the 16 RUN cycles; Decrypt = 1 → 15,14,...,0.
  - Toggling Decrypt mid-run does not change the sequence.
- Golden vector: bench f-function model (E, XOR, S-boxes, P) with key 133457799BBCDFF1 and plaintext 0123456789ABCDEF after IP.
  - Required: DataOut (before FP) = R16L16 = 0A4CD995_43423234 in DES bit order.
  - Decrypt of that result with Decrypt = 1 restores L0/R0.
- Back-to-back and ignored Start: Start held high continuously → Done every 17 cycles with correct results for each new DataIn.
  - A Start pulse during RUN is ignored: no restart, and the result matches the first block.

Source files
------------

// File: rtl/des_round_engine.sv
// Iterative DES Feistel round controller: holds L/R, steps one round per clock
// against an external f-function and delivers the pre-output block R16||L16.
//
// state | meaning
// IDLE  | waiting for Start; RightOut shows the last R half
// RUN   | one Feistel round per edge; f-function consumes RightOut/SubkeyIdx
// DONE  | single cycle with Done high; Start here reloads with no bubble
module des_round_engine #(
    parameter int ROUNDS = 16
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        Start,
    input  logic        Decrypt,
    input  logic [63:0] DataIn,
    input  logic [31:0] FOut,
    output logic [31:0] RightOut,
    output logic [3:0]  SubkeyIdx,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] DataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_t      state;
    logic [31:0] l_half;
    logic [31:0] r_half;
    logic [3:0]  rnd;
    logic        dec_q;
    logic [31:0] r_next;
    logic [3:0]  idx_rnd;

    assign r_next   = l_half ^ FOut;
    assign RightOut = r_half;

    // Outside RUN the key schedule sees the round-0 index for the stored direction.
    assign idx_rnd   = (state == RUN) ? rnd : 4'd0;
    assign SubkeyIdx = dec_q ? (4'd15 - idx_rnd) : idx_rnd;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= IDLE;
            l_half  <= '0;
            r_half  <= '0;
            rnd     <= '0;
            dec_q   <= 1'b0;
            DataOut <= '0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        l_half <= DataIn[31:0];
                        r_half <= DataIn[63:32];
                        rnd    <= '0;
                        dec_q  <= Decrypt;
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    l_half <= r_half;
                    r_half <= r_next;
                    if (rnd == LAST_RND) begin
                        // Counter is cleared rather than incremented so it never wraps.
                        rnd     <= '0;
                        DataOut <= {r_half, r_next};
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine with a reference DES f-function
// (E, key mix, S-boxes, P) and key schedule driving FOut combinationally.
module tb_des_round_engine;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        Start = 1'b0;
    logic        Decrypt = 1'b0;
    logic [63:0] DataIn = '0;
    logic [31:0] FOut;
    logic [31:0] RightOut;
    logic [3:0]  SubkeyIdx;
    logic        Busy;
    logic        Done;
    logic [63:0] DataOut;

    int checks = 0;
    int failures = 0;
    int fmode = 0;

    logic [47:0] ksub [16];

    des_round_engine #(.ROUNDS(16)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .Start     (Start),
        .Decrypt   (Decrypt),
        .DataIn    (DataIn),
        .FOut      (FOut),
        .RightOut  (RightOut),
        .SubkeyIdx (SubkeyIdx),
        .Busy      (Busy),
        .Done      (Done),
        .DataOut   (DataOut)
    );

    always #5 Clk = ~Clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[i] = v[31-i];
        return o;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[i] = v[63-i];
        return o;
    endfunction

    // Textbook bit order here: DES bit n sits at position (width - n).
    function automatic logic [31:0] f_conv(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
        x = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            s[31-4*b -: 4] = 4'(SBOX[idx]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
        return p;
    endfunction

    always_comb begin
        FOut = '0;
        case (fmode)
            0:       FOut = '0;
            1:       FOut = '1;
            default: FOut = rev32(f_conv(rev32(RightOut), ksub[SubkeyIdx]));
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] din, input logic dec, input bit chk_idx,
                          input bit tog, input bit poke,
                          output logic [63:0] res, output int lat);
        @(negedge Clk);
        DataIn  = din;
        Decrypt = dec;
        Start   = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        DataIn = ~din;
        lat    = 1;
        while (!Done && lat < 40) begin
            if (chk_idx && lat <= 16)
                check("subkey_idx", 64'(SubkeyIdx), 64'(dec ? 16 - lat : lat - 1));
            if (tog && lat == 8) Decrypt = ~dec;
            if (poke) Start = (lat == 5);
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
        res   = DataOut;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] key;
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [63:0] res;
        logic [63:0] din_g;
        logic [63:0] exp_g;
        int          lat;

        key = 64'h133457799BBCDFF1;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ksub[r][47-i] = cd[56-PC2[i]];
        end
        din_g = rev64(64'hCC00CCFFF0AAF0AA);
        exp_g = rev64(64'h0A4CD99543423234);

        repeat (2) @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dataout", DataOut, 64'd0);
        check("rst_rightout", 64'(RightOut), 64'd0);
        check("rst_subkey_idx", 64'(SubkeyIdx), 64'd0);
        RstN = 1'b1;

        // zero f: halves swap, latency 17, encrypt key order
        fmode = 0;
        run_op(64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0, 1'b0, res, lat);
        check("zero_f_latency", 64'(lat), 64'd17);
        check("zero_f_dataout", res, 64'h89ABCDEF01234567);
        @(negedge Clk);
        check("done_pulse_drop", 64'(Done), 64'd0);
        check("idle_busy", 64'(Busy), 64'd0);

        // decrypt key order with Decrypt toggled mid-run
        run_op(64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, res, lat);
        check("dec_zero_f_dataout", res, 64'h89ABCDEF01234567);
        @(negedge Clk);
        check("idle_subkey_idx_dec", 64'(SubkeyIdx), 64'd15);

        fmode = 1;
        run_op(64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0, 1'b0, res, lat);
        check("const_f_latency", 64'(lat), 64'd17);
        check("const_f_dataout", res, 64'h76543210FEDCBA98);

        fmode = 2;
        run_op(din_g, 1'b0, 1'b0, 1'b0, 1'b0, res, lat);
        check("golden_enc", res, exp_g);
        run_op(exp_g, 1'b1, 1'b0, 1'b0, 1'b0, res, lat);
        check("golden_dec", res, din_g);

        // Start pulse during RUN must not restart the block
        run_op(din_g, 1'b0, 1'b0, 1'b0, 1'b1, res, lat);
        check("ignored_start_latency", 64'(lat), 64'd17);
        check("ignored_start_dataout", res, exp_g);

        // back-to-back with Start held high
        fmode = 1;
        @(negedge Clk);
        DataIn  = 64'h1111111122222222;
        Decrypt = 1'b0;
        Start   = 1'b1;
        @(negedge Clk);
        DataIn = 64'hA5A5A5A53C3C3C3C;
        lat    = 1;
        while (!Done && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        check("b2b_first_latency", 64'(lat), 64'd17);
        check("b2b_first_dataout", DataOut, 64'h2222222211111111);
        @(negedge Clk);
        DataIn = 64'hDEADBEEFCAFEF00D;
        lat    = 1;
        check("b2b_no_bubble_busy", 64'(Busy), 64'd1);
        while (!Done && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
        check("b2b_second_latency", 64'(lat), 64'd17);
        check("b2b_second_dataout", DataOut, 64'h3C3C3C3CA5A5A5A5);
        @(negedge Clk);
        check("b2b_back_to_idle", 64'(Busy), 64'd0);

        // asynchronous reset at round 7
        fmode = 0;
        @(negedge Clk);
        DataIn = 64'h0011223344556677;
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        #2 RstN = 1'b0;
        #1;
        check("midrun_rst_busy", 64'(Busy), 64'd0);
        check("midrun_rst_done", 64'(Done), 64'd0);
        check("midrun_rst_dataout", DataOut, 64'd0);
        @(negedge Clk);
        RstN = 1'b1;
        run_op(64'h0011223344556677, 1'b0, 1'b0, 1'b0, 1'b0, res, lat);
        check("post_rst_latency", 64'(lat), 64'd17);
        check("post_rst_dataout", res, 64'h4455667700112233);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
